// File: rtl/demo_display_scan.sv
// Multiplexed N-digit seven-segment scan of a captured result value, with
// optional leading-zero blanking, freeze/hold, and a periodic CPU step enable.
module demo_display_scan #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned STEP_DIV    = 50000000,
   parameter int unsigned BLANK_LZ    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     value,
   input  logic                  value_valid,
   input  logic                  freeze,
   output logic                  step_tick,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int unsigned RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned SCNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned VAL_NIB = (DATA_W + 3) / 4;
   localparam int unsigned NIB_N  = (NUM_DIGITS > VAL_NIB) ? NUM_DIGITS : VAL_NIB;
   localparam int unsigned EXT_W  = NIB_N * 4;

   logic [DATA_W-1:0] disp_reg;
   logic [RCNT_W-1:0] rcnt;
   logic [SCNT_W-1:0] scnt;
   logic [IDX_W-1:0]  idx;

   logic [EXT_W-1:0]  ext;
   logic [3:0]        cur_nib;
   int unsigned       hi_nib;
   logic              blank_c;
   logic [6:0]        seg_nxt;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign ext = EXT_W'(disp_reg);

   // Select the active nibble and find the highest nonzero nibble of the held value
   always_comb begin
      cur_nib = 4'h0;
      hi_nib  = 0;
      for (int unsigned k = 0; k < NIB_N; k++) begin
         if (ext[k*4 +: 4] != 4'h0) hi_nib = k;
         if ((k < NUM_DIGITS) && (32'(idx) == k)) cur_nib = ext[k*4 +: 4];
      end
      blank_c = (BLANK_LZ != 0) && (32'(idx) > hi_nib);
      seg_nxt = blank_c ? 7'h7F : decode(cur_nib);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         disp_reg  <= '0;
         rcnt      <= '0;
         scnt      <= '0;
         idx       <= '0;
         step_tick <= 1'b0;
         an        <= '1;
         seg       <= 7'h7F;
         dp        <= 1'b1;
      end else begin
         if (value_valid && !freeze) disp_reg <= value;

         if (rcnt == RCNT_W'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         end else begin
            rcnt <= rcnt + RCNT_W'(1);
         end

         scnt      <= (scnt == SCNT_W'(STEP_DIV - 1)) ? '0 : scnt + SCNT_W'(1);
         step_tick <= (scnt == SCNT_W'(STEP_DIV - 1));

         // Outputs follow the current idx together so an/seg/dp stay aligned
         an  <= ~(NUM_DIGITS'(1) << idx);
         seg <= seg_nxt;
         dp  <= !((idx == '0) && freeze);
      end
   end

endmodule

// File: tb/tb_demo_display_scan.sv
// Directed bench for demo_display_scan: reset, scan, decode, blanking, freeze,
// step pulse timing and the fastest-divider configuration.
module tb_demo_display_scan;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] value = 16'h0;
   logic        value_valid = 1'b0;
   logic        freeze = 1'b0;

   logic       step0, step1, step2;
   logic [3:0] an0, an1, an2;
   logic [6:0] seg0, seg1, seg2;
   logic       dp0, dp1, dp2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   demo_display_scan #(.DATA_W(16), .NUM_DIGITS(4), .REFRESH_DIV(4), .STEP_DIV(5), .BLANK_LZ(1)) u0 (
      .clk(clk), .reset(reset), .value(value), .value_valid(value_valid), .freeze(freeze),
      .step_tick(step0), .an(an0), .seg(seg0), .dp(dp0));

   demo_display_scan #(.DATA_W(16), .NUM_DIGITS(4), .REFRESH_DIV(4), .STEP_DIV(5), .BLANK_LZ(0)) u1 (
      .clk(clk), .reset(reset), .value(value), .value_valid(value_valid), .freeze(freeze),
      .step_tick(step1), .an(an1), .seg(seg1), .dp(dp1));

   demo_display_scan #(.DATA_W(16), .NUM_DIGITS(4), .REFRESH_DIV(1), .STEP_DIV(1), .BLANK_LZ(1)) u2 (
      .clk(clk), .reset(reset), .value(value), .value_valid(value_valid), .freeze(freeze),
      .step_tick(step2), .an(an2), .seg(seg2), .dp(dp2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Capture v on the first edge after reset release, then watch 17 edges of scan
   task automatic scan(input string tag, input logic [15:0] v, input logic fz,
                       input logic [27:0] exp_b, input logic [27:0] exp_n);
      int d, d2;
      logic [3:0] ea, ea2;
      logic exp_step, exp_dp, exp_dp2;
      reset = 1'b1; value_valid = 1'b0; freeze = 1'b0;
      tick();
      reset = 1'b0; value = v; value_valid = 1'b1;
      for (int e = 1; e <= 17; e++) begin
         tick();
         d  = ((e - 1) / 4) % 4;
         d2 = (e - 1) % 4;
         ea  = ~(4'b0001 << d);
         ea2 = ~(4'b0001 << d2);
         exp_step = ((e % 5) == 0);
         exp_dp  = (e >= 2) ? !(fz && (d == 0)) : 1'b1;
         exp_dp2 = (e >= 2) ? !(fz && (d2 == 0)) : 1'b1;
         check({tag, " an0"}, 32'(an0), 32'(ea));
         check({tag, " an1"}, 32'(an1), 32'(ea));
         check({tag, " an2"}, 32'(an2), 32'(ea2));
         check({tag, " step0"}, 32'(step0), 32'(exp_step));
         check({tag, " step1"}, 32'(step1), 32'(exp_step));
         check({tag, " step2"}, 32'(step2), 32'(1'b1));
         check({tag, " dp0"}, 32'(dp0), 32'(exp_dp));
         check({tag, " dp1"}, 32'(dp1), 32'(exp_dp));
         check({tag, " dp2"}, 32'(dp2), 32'(exp_dp2));
         if (e >= 2) begin
            check({tag, " seg0"}, 32'(seg0), 32'(exp_b[d*7 +: 7]));
            check({tag, " seg1"}, 32'(seg1), 32'(exp_n[d*7 +: 7]));
            check({tag, " seg2"}, 32'(seg2), 32'(exp_b[d2*7 +: 7]));
         end
         if (e == 1) begin
            value_valid = fz;
            freeze = fz;
            if (fz) value = 16'h0001;
         end
      end
      value_valid = 1'b0;
      freeze = 1'b0;
   endtask

   initial begin
      // Held reset
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst an0", 32'(an0), 32'h0000000F);
         check("rst seg0", 32'(seg0), 32'h0000007F);
         check("rst dp0", 32'(dp0), 32'h1);
         check("rst step0", 32'(step0), 32'h0);
         check("rst an2", 32'(an2), 32'h0000000F);
         check("rst step2", 32'(step2), 32'h0);
      end

      scan("v1234", 16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19});
      scan("v0005", 16'h0005, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h12}, {7'h40, 7'h40, 7'h40, 7'h12});
      scan("v0000", 16'h0000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40});
      scan("v0050", 16'h0050, 1'b0, {7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h40, 7'h40, 7'h12, 7'h40});
      scan("v6789", 16'h6789, 1'b0, {7'h02, 7'h78, 7'h00, 7'h10}, {7'h02, 7'h78, 7'h00, 7'h10});
      scan("vEF07", 16'hEF07, 1'b0, {7'h06, 7'h0E, 7'h40, 7'h78}, {7'h06, 7'h0E, 7'h40, 7'h78});
      scan("frz", 16'hABCD, 1'b1, {7'h08, 7'h03, 7'h46, 7'h21}, {7'h08, 7'h03, 7'h46, 7'h21});

      // Step timing with a mid-count reset that also carries a capture strobe
      reset = 1'b1; value_valid = 1'b0; freeze = 1'b0;
      tick();
      reset = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         check("stp a", 32'(step0), 32'(e == 5));
      end
      reset = 1'b1; value = 16'hFFFF; value_valid = 1'b1;
      tick();
      check("mid rst an0", 32'(an0), 32'h0000000F);
      check("mid rst seg0", 32'(seg0), 32'h0000007F);
      check("mid rst step0", 32'(step0), 32'h0);
      reset = 1'b0; value_valid = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         check("stp b", 32'(step0), 32'((e % 5) == 0));
         if (e == 1) begin
            check("restart an0", 32'(an0), 32'h0000000E);
            check("restart seg0", 32'(seg0), 32'h00000040);
         end
         if (e == 5) check("restart an0 d1", 32'(an0), 32'h0000000D);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
